// File: rtl/fpcvt_pipe.sv
// Three-stage pipelined two's-complement to compact float converter (S, E, F, sat).
// Define FPCVT_RNE_EN for round-to-nearest-even; default rounds half-up on the guard bit.
module fpcvt_pipe #(
  parameter int unsigned IN_W   = 12,
  parameter int unsigned MANT_W = 4,
  parameter int unsigned EXP_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   D,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              S,
  output logic [EXP_W-1:0]  E,
  output logic [MANT_W-1:0] F,
  output logic              sat
);

  localparam int unsigned MAG_W = IN_W - 1;
  localparam int unsigned EMAX  = (1 << EXP_W) - 1;

  // Whole pipe moves together; stalls only when the output slot is full.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Stage 1: sign/magnitude, most-negative input clamps.
  logic [IN_W-1:0]  d_neg;
  logic             d_min;
  logic [MAG_W-1:0] d_mag;

  assign d_neg = -D;
  assign d_min = (D == {1'b1, {(IN_W-1){1'b0}}});

  always_comb begin
    d_mag = D[MAG_W-1:0];
    if (d_min)            d_mag = '1;
    else if (D[IN_W-1])   d_mag = d_neg[MAG_W-1:0];
  end

  logic             s1_valid, s1_s, s1_sat;
  logic [MAG_W-1:0] s1_mag;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_s     <= 1'b0;
      s1_sat   <= 1'b0;
      s1_mag   <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      s1_s     <= D[IN_W-1];
      s1_sat   <= d_min;
      s1_mag   <= d_mag;
    end
  end

  // Stage 2: leading-one detect and normalise to F plus guard (and sticky).
  int unsigned       lead;
  int unsigned       e_raw;
  logic [MANT_W:0]   fg;
  logic [EXP_W-1:0]  n_e;
  logic [MANT_W-1:0] n_f;
  logic              n_guard;
  logic              n_sat;
`ifdef FPCVT_RNE_EN
  logic [MAG_W-1:0]  lo_mask;
  logic              n_sticky;
`endif

  always_comb begin
    lead    = 0;
    e_raw   = 0;
    fg      = '0;
    n_e     = '0;
    n_f     = s1_mag[MANT_W-1:0];
    n_guard = 1'b0;
    n_sat   = s1_sat;
`ifdef FPCVT_RNE_EN
    lo_mask  = '0;
    n_sticky = 1'b0;
`endif
    for (int i = 0; i < int'(MAG_W); i++) begin
      if (s1_mag[i]) lead = i;
    end
    if (lead >= MANT_W) begin
      e_raw = lead - MANT_W + 1;
      if (e_raw > EMAX) begin
        // Out of range: clamp with guard cleared so stage 3 cannot round.
        n_e   = '1;
        n_f   = '1;
        n_sat = 1'b1;
      end else begin
        fg      = (MANT_W+1)'(s1_mag >> (lead - MANT_W));
        n_e     = EXP_W'(e_raw);
        n_f     = fg[MANT_W:1];
        n_guard = fg[0];
`ifdef FPCVT_RNE_EN
        lo_mask  = (MAG_W'(1) << (lead - MANT_W)) - MAG_W'(1);
        n_sticky = |(s1_mag & lo_mask);
`endif
      end
    end
  end

  logic              s2_valid, s2_s, s2_guard, s2_sat;
  logic [EXP_W-1:0]  s2_e;
  logic [MANT_W-1:0] s2_f;
`ifdef FPCVT_RNE_EN
  logic              s2_sticky;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      s2_s      <= 1'b0;
      s2_guard  <= 1'b0;
      s2_sat    <= 1'b0;
      s2_e      <= '0;
      s2_f      <= '0;
`ifdef FPCVT_RNE_EN
      s2_sticky <= 1'b0;
`endif
    end else if (advance) begin
      s2_valid  <= s1_valid;
      s2_s      <= s1_s;
      s2_guard  <= n_guard;
      s2_sat    <= n_sat;
      s2_e      <= n_e;
      s2_f      <= n_f;
`ifdef FPCVT_RNE_EN
      s2_sticky <= n_sticky;
`endif
    end
  end

  // Stage 3: round, renormalise on significand carry, saturate at the top.
  logic              round_up;
  logic [EXP_W-1:0]  r_e;
  logic [MANT_W-1:0] r_f;
  logic              r_sat;

  always_comb begin
`ifdef FPCVT_RNE_EN
    round_up = s2_guard && (s2_sticky || s2_f[0]);
`else
    round_up = s2_guard;
`endif
    r_e   = s2_e;
    r_f   = s2_f;
    r_sat = s2_sat;
    if (round_up) begin
      if (s2_f != '1) begin
        r_f = s2_f + MANT_W'(1);
      end else if (s2_e != '1) begin
        r_f = MANT_W'(1) << (MANT_W - 1);
        r_e = s2_e + EXP_W'(1);
      end else begin
        r_sat = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      S         <= 1'b0;
      E         <= '0;
      F         <= '0;
      sat       <= 1'b0;
    end else if (advance) begin
      out_valid <= s2_valid;
      S         <= s2_s;
      E         <= r_e;
      F         <= r_f;
      sat       <= r_sat;
    end
  end

endmodule

// File: tb/tb_fpcvt_pipe.sv
// Scoreboard bench for fpcvt_pipe: directed vectors, stalled stream, mid-flight reset.
module tb_fpcvt_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] D = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        S;
  logic [2:0]  E;
  logic [3:0]  F;
  logic        sat;

  fpcvt_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .D(D),
    .out_valid(out_valid), .out_ready(out_ready), .S(S), .E(E), .F(F), .sat(sat)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       s;
    logic [2:0] e;
    logic [3:0] f;
    logic       sat;
    int         cyc;
  } exp_t;

  exp_t       q[$];
  exp_t       nxt;
  int         total = 0;
  int         bad = 0;
  int         cycle = 0;
  bit         chk_lat = 1'b0;
  bit         stall_chk = 1'b0;
  bit         snap_take = 1'b0;
  bit         acc = 1'b0;
  logic       snap_s, snap_sat;
  logic [2:0] snap_e;
  logic [3:0] snap_f;
  logic [11:0] vals [8];
  int          idx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic s, input logic [2:0] e, input logic [3:0] f, input logic st);
    exp_t x;
    x.s = s; x.e = e; x.f = f; x.sat = st; x.cyc = 0;
    return x;
  endfunction

  // Arithmetic reference: divide down to 4 significand bits, round on the remainder.
  function automatic exp_t model(input int d);
    int mag, e, f, r, half;
    bit up, st;
    st  = (d == -2048);
    mag = st ? 2047 : (d < 0 ? -d : d);
    e = 0;
    f = mag;
    while (f >= 16) begin
      f = f / 2;
      e++;
    end
    r = mag - f * (1 << e);
    half = (e > 0) ? (1 << (e - 1)) : 0;
    up = 1'b0;
`ifdef FPCVT_RNE_EN
    if (e > 0) up = (r > half) || (r == half && (f % 2) == 1);
`else
    if (e > 0) up = (r >= half);
`endif
    if (up) f++;
    if (f == 16) begin
      f = 8;
      e++;
    end
    if (e > 7) begin
      e = 7;
      f = 15;
      st = 1'b1;
    end
    return mk(d < 0, 3'(e), 4'(f), st);
  endfunction

  // One clock: check outputs / record handshakes mid low-phase, then step to next negedge.
  task automatic cyc();
    exp_t x;
    #1;
    acc = 1'b0;
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("extra_out", 32'(out_valid), 32'(0));
      end else begin
        x = q.pop_front();
        check("S", 32'(S), 32'(x.s));
        check("E", 32'(E), 32'(x.e));
        check("F", 32'(F), 32'(x.f));
        check("sat", 32'(sat), 32'(x.sat));
        if (chk_lat) check("latency", 32'(cycle - x.cyc), 32'(3));
      end
    end
    if (stall_chk) begin
      check("stall_in_ready", 32'(in_ready), 32'(0));
      check("stall_out_valid", 32'(out_valid), 32'(1));
      if (snap_take) begin
        snap_s = S; snap_e = E; snap_f = F; snap_sat = sat;
        snap_take = 1'b0;
      end else begin
        check("hold_S", 32'(S), 32'(snap_s));
        check("hold_E", 32'(E), 32'(snap_e));
        check("hold_F", 32'(F), 32'(snap_f));
        check("hold_sat", 32'(sat), 32'(snap_sat));
      end
    end
    if (!rst && in_valid && in_ready) begin
      nxt.cyc = cycle;
      q.push_back(nxt);
      acc = 1'b1;
    end
    @(negedge clk);
    cycle++;
  endtask

  task automatic send(input int d, input exp_t x);
    D = 12'(d);
    nxt = x;
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (acc) break;
    end
    check("accept", 32'(acc), 32'(1));
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int k = 0; k < 20 && q.size() > 0; k++) cyc();
    check("drain_empty", 32'(q.size()), 32'(0));
  endtask

  task automatic chk_reset_state(input string tag);
    #1;
    check({tag, "_out_valid"}, 32'(out_valid), 32'(0));
    check({tag, "_S"}, 32'(S), 32'(0));
    check({tag, "_E"}, 32'(E), 32'(0));
    check({tag, "_F"}, 32'(F), 32'(0));
    check({tag, "_sat"}, 32'(sat), 32'(0));
    check({tag, "_in_ready"}, 32'(in_ready), 32'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    chk_reset_state("reset");

    // Back-to-back directed results with exact 3-cycle latency.
    chk_lat = 1'b1;
    send(0,   mk(1'b0, 3'd0, 4'd0,  1'b0));
    send(13,  mk(1'b0, 3'd0, 4'd13, 1'b0));
    send(422, mk(1'b0, 3'd5, 4'd13, 1'b0));
    drain();

    send(125,   mk(1'b0, 3'd4, 4'd8,  1'b0));
    send(-125,  mk(1'b1, 3'd4, 4'd8,  1'b0));
    send(-2048, mk(1'b1, 3'd7, 4'd15, 1'b1));
    send(2047,  mk(1'b0, 3'd7, 4'd15, 1'b1));
`ifdef FPCVT_RNE_EN
    send(42,    mk(1'b0, 3'd2, 4'd10, 1'b0));
`else
    send(42,    mk(1'b0, 3'd2, 4'd11, 1'b0));
`endif
    send(46,    mk(1'b0, 3'd2, 4'd12, 1'b0));
    send(-1,    mk(1'b1, 3'd0, 4'd1,  1'b0));
    drain();
    chk_lat = 1'b0;

    // Streaming with a five-cycle output stall in the middle.
    for (int i = 0; i < 8; i++) vals[i] = 12'($urandom_range(0, 4095));
    idx = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 60 && idx < 8; c++) begin
      out_ready = !(c >= 4 && c < 9);
      stall_chk = (c >= 4 && c < 9);
      snap_take = (c == 4);
      D = vals[idx];
      nxt = model($signed(vals[idx]));
      cyc();
      if (acc) idx++;
    end
    stall_chk = 1'b0;
    out_ready = 1'b1;
    check("stream_accepted", 32'(idx), 32'(8));
    drain();

    // Reset with three samples in flight, input offered during reset.
    in_valid = 1'b1;
    D = 12'(100);  nxt = model(100);  cyc();
    D = 12'(200);  nxt = model(200);  cyc();
    D = 12'(-300); nxt = model(-300); cyc();
    rst = 1'b1;
    D = 12'(55);   nxt = model(55);   cyc();
    q.delete();
    rst = 1'b0;
    in_valid = 1'b0;
    chk_reset_state("midreset");
    chk_lat = 1'b1;
    send(77, model(77));
    drain();
    for (int k = 0; k < 6; k++) cyc();
    chk_lat = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
